// File: rtl/floor_scroll_sched.sv
// Scroll-episode sequencer and floor respawn arbiter for the four-floor datapath.
// The scroll side counts frames of a ceiling-hit episode and emits a 1 px step
// pulse whose rate halves in four phases. The respawn side hands out one
// floor-respawn request at a time, round-robin, with a pseudo-random new y.
module floor_scroll_sched #(
    parameter logic [9:0]  BOTTOM_Y  = 10'd470,
    parameter logic [9:0]  TOP_Y     = 10'd40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        hit_ceiling,
    input  logic        game_active,
    input  logic [39:0] floor_y_bus,
    output logic [8:0]  time_gap,
    output logic        scroll_active,
    output logic        scroll_step,
    output logic        req_valid,
    output logic [1:0]  req_idx,
    output logic [9:0]  req_y,
    input  logic        req_ack
);

    // An all-zero seed would lock the LFSR up, so fall back to a known value.
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [8:0]  GAP_LAST  = 9'd319;

    typedef enum logic [0:0] {StIdle, StScroll} scroll_state_e;
    typedef enum logic [1:0] {StRIdle, StRReq, StRCool} resp_state_e;

    scroll_state_e sc_state_q, sc_state_d;
    logic [8:0]    time_gap_q, time_gap_d;
    logic          step_q, step_d;
    logic          step_ok;

    resp_state_e   rs_state_q, rs_state_d;
    logic          req_valid_q, req_valid_d;
    logic [1:0]    req_idx_q, req_idx_d;
    logic [9:0]    req_y_q, req_y_d;
    logic [1:0]    rr_q, rr_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    need;
    logic [1:0]    sel_idx;
    logic          sel_found;

    // Decide whether the current time_gap earns a step; rate halves every 80 frames.
    always_comb begin
        if (time_gap_q < 9'd80) begin
            step_ok = (time_gap_q != 9'd0);
        end else if (time_gap_q < 9'd160) begin
            step_ok = ~time_gap_q[0];
        end else if (time_gap_q < 9'd240) begin
            step_ok = (time_gap_q[1:0] == 2'b00);
        end else begin
            step_ok = (time_gap_q[2:0] == 3'b000);
        end
    end

    // Scroll FSM next state: pause beats restart, restart beats a frame tick.
    always_comb begin
        sc_state_d = sc_state_q;
        time_gap_d = time_gap_q;
        step_d     = 1'b0;
        if (!game_active) begin
            sc_state_d = StIdle;
            time_gap_d = 9'd0;
        end else if (hit_ceiling) begin
            sc_state_d = StScroll;
            time_gap_d = 9'd1;
        end else if ((sc_state_q == StScroll) && frame_tick) begin
            step_d = step_ok;
            if (time_gap_q == GAP_LAST) begin
                sc_state_d = StIdle;
                time_gap_d = 9'd0;
            end else begin
                time_gap_d = time_gap_q + 9'd1;
            end
        end
    end

    // Scroll FSM state, counter and registered step pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_state_q <= StIdle;
            time_gap_q <= 9'd0;
            step_q     <= 1'b0;
        end else begin
            sc_state_q <= sc_state_d;
            time_gap_q <= time_gap_d;
            step_q     <= step_d;
        end
    end

    // Flag floors at or past the bottom edge and pick the next one after rr.
    always_comb begin
        logic [1:0] cand;
        for (int i = 0; i < 4; i++) begin
            need[i] = (floor_y_bus[10*i +: 10] >= BOTTOM_Y);
        end
        sel_idx   = 2'd0;
        sel_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_q + 2'(k);
            if (!sel_found && need[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Respawn FSM next state; a request is held untouched until acked.
    always_comb begin
        rs_state_d  = rs_state_q;
        req_valid_d = req_valid_q;
        req_idx_d   = req_idx_q;
        req_y_d     = req_y_q;
        rr_d        = rr_q;
        case (rs_state_q)
            StRIdle: begin
                if (sel_found) begin
                    req_idx_d   = sel_idx;
                    req_y_d     = TOP_Y + {4'd0, lfsr_q[5:0]};
                    req_valid_d = 1'b1;
                    rs_state_d  = StRReq;
                end
            end
            StRReq: begin
                if (req_ack) begin
                    req_valid_d = 1'b0;
                    rr_d        = req_idx_q;
                    rs_state_d  = StRCool;
                end
            end
            // One dead cycle lets floor_y_bus pick up the respawned position.
            StRCool: rs_state_d = StRIdle;
            default: rs_state_d = StRIdle;
        endcase
    end

    // LFSR free-runs every cycle so the drawn y depends on request timing.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Respawn FSM state, request registers, round-robin pointer and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_state_q  <= StRIdle;
            req_valid_q <= 1'b0;
            req_idx_q   <= 2'd0;
            req_y_q     <= 10'd0;
            rr_q        <= 2'd3;
            lfsr_q      <= LFSR_INIT;
        end else begin
            rs_state_q  <= rs_state_d;
            req_valid_q <= req_valid_d;
            req_idx_q   <= req_idx_d;
            req_y_q     <= req_y_d;
            rr_q        <= rr_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign time_gap      = time_gap_q;
    assign scroll_active = (sc_state_q == StScroll);
    assign scroll_step   = step_q;
    assign req_valid     = req_valid_q;
    assign req_idx       = req_idx_q;
    assign req_y         = req_y_q;

endmodule

// File: tb/tb_floor_scroll_sched.sv
// Bench for floor_scroll_sched: a vector table for single-cycle behaviour plus
// hand-written sequences for full episodes, restart, pause and the respawn handshake.
module tb_floor_scroll_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        hit_ceiling;
    logic        game_active;
    logic [39:0] floor_y_bus;
    logic [8:0]  time_gap;
    logic        scroll_active;
    logic        scroll_step;
    logic        req_valid;
    logic [1:0]  req_idx;
    logic [9:0]  req_y;
    logic        req_ack;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] BUS_LOW = {10'd100, 10'd100, 10'd100, 10'd100};
    localparam logic [39:0] BUS_B   = {10'd469, 10'd469, 10'd470, 10'd469};

    typedef struct packed {
        logic        rst;
        logic        tick;
        logic        hit;
        logic        act;
        logic        ack;
        logic [39:0] bus;
        logic [8:0]  tg;
        logic        sa;
        logic        st;
        logic        rv;
        logic [1:0]  idx;
    } vec_t;

    vec_t tbl [0:18];

    floor_scroll_sched dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .hit_ceiling   (hit_ceiling),
        .game_active   (game_active),
        .floor_y_bus   (floor_y_bus),
        .time_gap      (time_gap),
        .scroll_active (scroll_active),
        .scroll_step   (scroll_step),
        .req_valid     (req_valid),
        .req_idx       (req_idx),
        .req_y         (req_y),
        .req_ack       (req_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_step(input int tg);
        if (tg >= 1 && tg <= 79) return 1;
        if (tg >= 80 && tg <= 159) return (tg % 2 == 0) ? 1 : 0;
        if (tg >= 160 && tg <= 239) return (tg % 4 == 0) ? 1 : 0;
        if (tg >= 240 && tg <= 319) return (tg % 8 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        frame_tick  = 1'b0;
        hit_ceiling = 1'b0;
        req_ack     = 1'b0;
        game_active = 1'b1;
        floor_y_bus = BUS_LOW;
        tick_clk();
        rst = 1'b0;
    endtask

    // One frame: a tick cycle then a quiet cycle; reports the step seen after the tick.
    task automatic run_frame(output int stepped);
        frame_tick = 1'b1;
        tick_clk();
        frame_tick = 1'b0;
        stepped = int'(scroll_step);
        tick_clk();
    endtask

    task automatic hit_once();
        hit_ceiling = 1'b1;
        tick_clk();
        hit_ceiling = 1'b0;
    endtask

    initial begin
        int steps;
        int s;
        int n;
        int prev;
        int exp_tg;
        int low;
        logic [9:0] y_save;

        rst         = 1'b1;
        frame_tick  = 1'b0;
        hit_ceiling = 1'b0;
        game_active = 1'b1;
        req_ack     = 1'b0;
        floor_y_bus = BUS_LOW;

        //             rst   tick  hit   act   ack   bus      tg     sa    st    rv    idx
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BUS_LOW, 9'd1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd2, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd2, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, BUS_LOW, 9'd1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd2, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BUS_LOW, 9'd1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BUS_LOW, 9'd2, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BUS_LOW, 9'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUS_B,   9'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUS_B,   9'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUS_B,   9'd0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUS_B,   9'd0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BUS_B,   9'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BUS_B,   9'd0, 1'b0, 1'b0, 1'b0, 2'd1};

        for (int i = 0; i < 19; i++) begin
            rst         = tbl[i].rst;
            frame_tick  = tbl[i].tick;
            hit_ceiling = tbl[i].hit;
            game_active = tbl[i].act;
            req_ack     = tbl[i].ack;
            floor_y_bus = tbl[i].bus;
            tick_clk();
            chk($sformatf("vec%0d time_gap", i), int'(time_gap), int'(tbl[i].tg));
            chk($sformatf("vec%0d scroll_active", i), int'(scroll_active), int'(tbl[i].sa));
            chk($sformatf("vec%0d scroll_step", i), int'(scroll_step), int'(tbl[i].st));
            chk($sformatf("vec%0d req_valid", i), int'(req_valid), int'(tbl[i].rv));
            chk($sformatf("vec%0d req_idx", i), int'(req_idx), int'(tbl[i].idx));
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d req_y range", i), int'(req_y >= 10'd40 && req_y <= 10'd103), 1);
            end
        end

        // Full episode: idle frames, then one hit and 330 frames.
        do_reset();
        steps = 0;
        for (int f = 0; f < 10; f++) begin
            run_frame(s);
            steps += s;
        end
        chk("idle steps", steps, 0);
        chk("idle time_gap", int'(time_gap), 0);
        hit_once();
        chk("A load time_gap", int'(time_gap), 1);
        chk("A load step", int'(scroll_step), 0);
        exp_tg = 1;
        steps  = 0;
        for (int f = 0; f < 330; f++) begin
            prev = exp_tg;
            frame_tick = 1'b1;
            tick_clk();
            frame_tick = 1'b0;
            exp_tg = (prev == 0 || prev == 319) ? 0 : prev + 1;
            chk($sformatf("A tg frame%0d", f), int'(time_gap), exp_tg);
            chk($sformatf("A active frame%0d", f), int'(scroll_active), (exp_tg != 0) ? 1 : 0);
            chk($sformatf("A step frame%0d", f), int'(scroll_step), exp_step(prev));
            steps += int'(scroll_step);
            tick_clk();
            steps += int'(scroll_step);
        end
        chk("A total steps", steps, 149);

        // Restart at time_gap 200 with a coincident frame tick.
        do_reset();
        hit_once();
        n = 0;
        while (time_gap != 9'd200 && n < 400) begin
            run_frame(s);
            n++;
        end
        chk("B reach 200", int'(time_gap), 200);
        hit_ceiling = 1'b1;
        frame_tick  = 1'b1;
        tick_clk();
        hit_ceiling = 1'b0;
        frame_tick  = 1'b0;
        chk("B restart time_gap", int'(time_gap), 1);
        chk("B restart step", int'(scroll_step), 0);
        chk("B restart active", int'(scroll_active), 1);
        tick_clk();
        run_frame(s);
        chk("B first step", s, 1);
        steps = s;
        for (int f = 0; f < 330; f++) begin
            run_frame(s);
            steps += s;
        end
        chk("B total steps", steps, 149);
        chk("B end time_gap", int'(time_gap), 0);
        chk("B end active", int'(scroll_active), 0);

        // Pause at time_gap 50; hit while paused must be ignored.
        do_reset();
        hit_once();
        n = 0;
        while (time_gap != 9'd50 && n < 100) begin
            run_frame(s);
            n++;
        end
        chk("C reach 50", int'(time_gap), 50);
        game_active = 1'b0;
        frame_tick  = 1'b1;
        tick_clk();
        frame_tick = 1'b0;
        chk("C pause time_gap", int'(time_gap), 0);
        chk("C pause active", int'(scroll_active), 0);
        chk("C pause step", int'(scroll_step), 0);
        hit_once();
        chk("C hit paused time_gap", int'(time_gap), 0);
        chk("C hit paused active", int'(scroll_active), 0);
        steps = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(s);
            steps += s;
        end
        chk("C paused steps", steps, 0);
        chk("C paused time_gap", int'(time_gap), 0);
        game_active = 1'b1;

        // Round-robin respawn: floors 0 and 2 below the edge.
        do_reset();
        floor_y_bus = {10'd100, 10'd475, 10'd100, 10'd475};
        n = 0;
        while (!req_valid && n < 10) begin
            tick_clk();
            n++;
        end
        chk("D first valid", int'(req_valid), 1);
        chk("D first idx", int'(req_idx), 0);
        chk("D first y range", int'(req_y >= 10'd40 && req_y <= 10'd103), 1);
        y_save = req_y;
        for (int c = 0; c < 2; c++) begin
            tick_clk();
            chk("D first hold valid", int'(req_valid), 1);
            chk("D first hold idx", int'(req_idx), 0);
            chk("D first hold y", int'(req_y), int'(y_save));
        end
        req_ack = 1'b1;
        floor_y_bus[9:0] = 10'd100;
        tick_clk();
        req_ack = 1'b0;
        chk("D ack drops valid", int'(req_valid), 0);
        low = 1;
        n   = 0;
        while (!req_valid && n < 10) begin
            tick_clk();
            if (!req_valid) low++;
            n++;
        end
        chk("D second valid", int'(req_valid), 1);
        chk("D second idx", int'(req_idx), 2);
        chk("D second y range", int'(req_y >= 10'd40 && req_y <= 10'd103), 1);
        chk("D cooldown gap", int'(low >= 1), 1);
        y_save = req_y;
        for (int c = 0; c < 2; c++) begin
            tick_clk();
            chk("D second hold y", int'(req_y), int'(y_save));
        end
        req_ack = 1'b1;
        tick_clk();
        req_ack = 1'b0;
        chk("D second ack drops valid", int'(req_valid), 0);

        // Held request on floor 3 with game_active toggling, then reset mid-hold.
        do_reset();
        floor_y_bus = {10'd480, 10'd100, 10'd100, 10'd100};
        n = 0;
        while (!req_valid && n < 10) begin
            tick_clk();
            n++;
        end
        chk("E valid", int'(req_valid), 1);
        chk("E idx", int'(req_idx), 3);
        y_save = req_y;
        for (int c = 0; c < 20; c++) begin
            game_active = c[0];
            tick_clk();
            chk($sformatf("E hold valid c%0d", c), int'(req_valid), 1);
            chk($sformatf("E hold idx c%0d", c), int'(req_idx), 3);
            chk($sformatf("E hold y c%0d", c), int'(req_y), int'(y_save));
        end
        game_active = 1'b1;
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        chk("E rst time_gap", int'(time_gap), 0);
        chk("E rst active", int'(scroll_active), 0);
        chk("E rst step", int'(scroll_step), 0);
        chk("E rst valid", int'(req_valid), 0);
        chk("E rst idx", int'(req_idx), 0);
        chk("E rst y", int'(req_y), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/floor_scroll_sched.md
Name: floor_scroll_sched

Overview:
- Scheduler and controller for the four-floor position datapath.
- Sequences ceiling-hit scroll episodes: owns the time_gap counter and emits one step pulse per frame when the floors must move down 1 px, with speed decaying in four phases.
- Arbitrates respawn of floors that have scrolled past the bottom edge: round-robin over 4 floors, one valid/ack request at a time, new y drawn from an LFSR.

Parameters:
- BOTTOM_Y, 470, floor y at or above which a floor needs respawn (unsigned 10-bit compare).
- TOP_Y, 40, base y for a respawned floor.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- hit_ceiling  in  1  one-cycle pulse: player touched the ceiling
- game_active  in  1  low = play paused/over
- floor_y_bus  in  40  {y3,y2,y1,y0}, 10 bits each, current floor y
- time_gap  out  9  scroll episode frame counter (0 = idle)
- scroll_active  out  1  high while an episode runs
- scroll_step  out  1  one-cycle pulse: move all floors +1 px
- req_valid  out  1  respawn request valid
- req_idx  out  2  floor index to respawn
- req_y  out  10  new y for that floor
- req_ack  in  1  consumer accepts request this cycle

Behaviour:
- Reset (sync, rst high, overrides all inputs): time_gap=0, scroll_active=0, scroll_step=0, req_valid=0, req_idx=0, req_y=0, rr pointer=3 (so idx 0 wins first), LFSR=LFSR_SEED, both FSMs idle.
- Scroll FSM states:
  - IDLE: time_gap=0. hit_ceiling && game_active -> time_gap=1, SCROLL. No step in the load cycle.
  - SCROLL: on frame_tick, scroll_step=1 in the next cycle (registered, 1-cycle latency) iff the current time_gap satisfies:
    - 1..79: always.
    - 80..159: time_gap[0]==0.
    - 160..239: time_gap[1:0]==0.
    - 240..319: time_gap[2:0]==0.
  - In the same tick, time_gap increments. A tick at time_gap==319 sets time_gap=0 and moves to IDLE; the step for 319 is not issued (bits not 000).
  - Steps per full episode: 79+40+20+10 = 149.
- scroll_active = (state==SCROLL), registered.
- Simultaneous events:
  - hit_ceiling in SCROLL restarts: time_gap=1, no step that cycle, even with a coincident frame_tick.
  - game_active low forces IDLE, time_gap=0, and suppresses scroll_step in the following cycle.
- time_gap never exceeds 319 and never wraps.
- Respawn FSM states:
  - R_IDLE: need[i] = (y_i >= BOTTOM_Y). If any need, select the first set bit scanning from rr+1 mod 4 upward with wrap, then register req_idx=idx, req_y=TOP_Y+lfsr[5:0] (range TOP_Y..TOP_Y+63), req_valid=1 -> R_REQ.
  - R_REQ: req_valid, req_idx and req_y are held stable until req_ack. On ack: req_valid=0 next cycle, rr=req_idx -> R_COOL. req_ack while req_valid=0 is ignored.
  - R_COOL: one cycle, no request, so that floor_y_bus reflects the respawned floor -> R_IDLE.
- req_valid is never withdrawn without ack, including while game_active=0. Only rst cancels it mid-handshake.
- Respawn runs independently of the scroll FSM; a respawn and a scroll_step may coincide.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every clk cycle regardless of state.

Test Plan:
- Reset, idle 10 frames, then hit_ceiling while game_active=1, run 330 frame_ticks -> exactly 149 scroll_step pulses; time_gap counts 1..319 then returns to 0; scroll_active falls on the tick at time_gap 319.
- Restart mid-episode: hit_ceiling at time_gap=200, coincident with a frame_tick -> time_gap=1, no step that cycle; the next tick steps, then 149 steps until idle.
- Pause: game_active=0 at time_gap=50 -> time_gap=0, scroll_active=0, no further steps; hit_ceiling while paused is ignored.
- Respawn round-robin: y0=y2=475, y1=y3=100, ack each request 3 cycles after valid -> request idx0 then idx2; req_y stays in 40..103 and stable until ack; valid low for ≥1 cycle (cool-down) between requests.
- Held request: y3=480, req_ack withheld 20 cycles with game_active toggling -> req_valid, req_idx=3 and req_y unchanged; rst asserted mid-hold -> all outputs 0 on the next cycle.
